// File: rtl/exec_result_fifo_if.sv
// rtl/exec_result_fifo_if.sv - producer/consumer/status bundle for the execution result FIFO
interface exec_result_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              clear;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        out_seq;
    logic              out_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [7:0]        drop_count;

    modport master (
        output in_valid, in_data, clear, out_ready,
        input  out_valid, out_data, out_seq, count, full, empty, overflow, drop_count
    );

    modport slave (
        input  in_valid, in_data, clear, out_ready,
        output out_valid, out_data, out_seq, count, full, empty, overflow, drop_count
    );
endinterface

// File: rtl/exec_result_fifo.sv
// rtl/exec_result_fifo.sv - sequence-tagged FWFT result FIFO with overflow and drop statistics
module exec_result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    exec_result_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W+7:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_seq;
    logic [7:0]        r_drop_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_drop;
    logic [DATA_W+7:0] w_head;

    // Status comes only from registered count, so in_valid never reaches full combinationally.
    assign w_full    = (r_count == LP_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && bus.out_ready;
    assign w_push_ok = bus.in_valid && (!w_full || w_pop);
    assign w_drop    = bus.in_valid && w_full && !w_pop;
    assign w_head    = r_mem[r_rd_ptr];

    assign bus.out_valid  = !w_empty;
    assign bus.out_data   = w_head[DATA_W-1:0];
    assign bus.out_seq    = w_head[DATA_W+7:DATA_W];
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;

    // Storage is intentionally left unreset; head contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (reset_n && !bus.clear && w_push_ok) begin
            r_mem[r_wr_ptr] <= {r_seq, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_seq        <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_seq        <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                r_seq    <= r_seq + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_result_fifo.sv
// tb/tb_exec_result_fifo.sv - directed and randomized checks of exec_result_fifo against a queue model
module tb_exec_result_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    exec_result_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    exec_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int seq;
        int data;
    } entry_t;

    entry_t q[$];
    int     m_seq   = 0;
    int     m_drops = 0;
    bit     m_ovf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_seq   = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_model(input string where);
        check({where, ".count"},      32'(bus.count),      32'(q.size()));
        check({where, ".full"},       32'(bus.full),       32'(q.size() == DEPTH));
        check({where, ".empty"},      32'(bus.empty),      32'(q.size() == 0));
        check({where, ".out_valid"},  32'(bus.out_valid),  32'(q.size() != 0));
        check({where, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
        check({where, ".drop_count"}, 32'(bus.drop_count), 32'(m_drops));
        if (q.size() != 0) begin
            check({where, ".out_data"}, 32'(bus.out_data), 32'(q[0].data));
            check({where, ".out_seq"},  32'(bus.out_seq),  32'(q[0].seq));
        end
    endtask

    // One clock: drive inputs, check the pre-edge view, then advance the model by the rules.
    task automatic step(input bit v, input int d, input bit rdy, input bit clr);
        bit     pop;
        bit     push_ok;
        entry_t e;
        bus.in_valid  = v;
        bus.in_data   = DATA_W'(d);
        bus.out_ready = rdy;
        bus.clear     = clr;
        @(negedge clk);
        check_model("step");
        pop = (q.size() != 0) && rdy;
        if (clr) begin
            model_reset();
        end else begin
            push_ok = v && ((q.size() < DEPTH) || pop);
            if (pop) void'(q.pop_front());
            if (push_ok) begin
                e.seq  = m_seq;
                e.data = d & 8'hFF;
                q.push_back(e);
                m_seq = (m_seq + 1) % 256;
            end else if (v) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.count",      32'(bus.count),      0);
        check("rst.empty",      32'(bus.empty),      1);
        check("rst.full",       32'(bus.full),       0);
        check("rst.out_valid",  32'(bus.out_valid),  0);
        check("rst.overflow",   32'(bus.overflow),   0);
        check("rst.drop_count", 32'(bus.drop_count), 0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Push three, hold, then drain in order.
        step(1, 8'h03, 0, 0);
        step(1, 8'h05, 0, 0);
        step(1, 8'h07, 0, 0);
        check("p3.count",    32'(bus.count),    3);
        check("p3.out_data", 32'(bus.out_data), 32'h03);
        check("p3.out_seq",  32'(bus.out_seq),  0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("drain.empty", 32'(bus.empty), 1);

        // Overfill by two.
        step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 8'h10 + i, 0, 0);
        check("ovf.full",       32'(bus.full),       1);
        check("ovf.count",      32'(bus.count),      4);
        check("ovf.overflow",   32'(bus.overflow),   1);
        check("ovf.drop_count", 32'(bus.drop_count), 2);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // Push at full with a simultaneous pop is accepted.
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 8'h20 + i, 0, 0);
        step(1, 8'hAA, 1, 0);
        check("pp.count",    32'(bus.count),    4);
        check("pp.overflow", 32'(bus.overflow), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("pp.tail_data", 32'(bus.out_data), 32'hAA);
        check("pp.tail_seq",  32'(bus.out_seq),  4);
        step(0, 0, 1, 0);

        // Sequence tag wraps after 256 entries.
        step(0, 0, 0, 1);
        for (int i = 0; i < 257; i++) step(1, i, 1, 0);
        check("wrap.count",   32'(bus.count),   1);
        check("wrap.out_seq", 32'(bus.out_seq), 0);
        step(0, 0, 1, 0);

        // Drop counter saturates.
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, i, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 8'h55, 0, 0);
        check("sat.drop_count", 32'(bus.drop_count), 255);

        // Clear beats a concurrent push and pop.
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 8'h30 + i, 0, 0);
        step(1, 8'h99, 1, 1);
        check("clr.count",      32'(bus.count),      0);
        check("clr.empty",      32'(bus.empty),      1);
        check("clr.overflow",   32'(bus.overflow),   0);
        check("clr.drop_count", 32'(bus.drop_count), 0);
        step(1, 8'h42, 0, 0);
        check("clr.out_seq",  32'(bus.out_seq),  0);
        check("clr.out_data", 32'(bus.out_data), 32'h42);

        // Asynchronous reset between edges with two entries held.
        step(1, 8'h43, 0, 0);
        bus.in_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("arst.count",     32'(bus.count),     0);
        check("arst.empty",     32'(bus.empty),     1);
        check("arst.out_valid", 32'(bus.out_valid), 0);
        check("arst.overflow",  32'(bus.overflow),  0);
        model_reset();
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 255),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/exec_result_fifo.md
Name: exec_result_fifo

Overview:
Downstream stage of the IDLE/LOAD/EXEC/STORE/DONE execution FSM. Captures one result word per STORE strobe and tags each with a sequence number. Buffers results in a small first-word-fall-through FIFO that a consumer drains with a valid/ready handshake. Reports occupancy, overflow and drop statistics so VCD dumps show buffering behaviour alongside FSM state.

Parameters:
DATA_W, 8, width of result word (matches FSM counter width)
DEPTH, 4, FIFO entries; power of two, >= 2
ADDR_W, 2, log2(DEPTH); must be consistent with DEPTH

Ports:
clk  input  1  system clock, all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  store strobe from the execution FSM, one result per asserted cycle
in_data  input  DATA_W  result word, sampled when in_valid=1
clear  input  1  synchronous flush
out_valid  output  1  head entry present
out_data  output  DATA_W  head result word
out_seq  output  8  sequence tag of head entry
out_ready  input  1  consumer accepts head when out_valid && out_ready
count  output  ADDR_W+1  entries held, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a push was dropped
drop_count  output  8  dropped pushes, saturating

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset (reset_n=0, any time, including mid-operation): count=0, empty=1, full=0, out_valid=0, overflow=0, drop_count=0, sequence counter=0, read/write pointers=0.
- While reset_n=0, outputs hold reset values regardless of clk.
- Storage contents need not be reset.
- out_data and out_seq are don't-care while out_valid=0.
- pop = out_valid && out_ready.
- push_ok = in_valid && (!full || pop).
- Push at full succeeds only if a pop occurs in the same cycle.
- Accepted push: write {seq, in_data} at wr_ptr, advance wr_ptr (wraps mod DEPTH), then seq <= seq+1 (8-bit, 255 wraps to 0).
- First pushed entry gets seq 0 after reset or clear.
- Pop: advance rd_ptr (wraps mod DEPTH).
- count: +1 on push_ok without pop; -1 on pop without push_ok; unchanged when both occur or neither occurs.
- Latency: an entry pushed at edge N is visible on out_valid/out_data/out_seq after edge N (FWFT, combinational read of head). It can be popped at the next edge.
- Simultaneous push and pop with count==0 is impossible: pop requires out_valid. The push is accepted and count becomes 1.
- Dropped push (in_valid && full && !pop):
  - no write; seq unchanged; pointers unchanged;
  - overflow <= 1 (sticky until clear/reset);
  - drop_count <= drop_count+1, saturating at 255.
- clear=1 at an edge:
  - pointers=0, count=0, seq=0, overflow=0, drop_count=0;
  - any push or pop in the same cycle is ignored;
  - clear has top priority after reset.
- full, empty and out_valid (= !empty) derive from count, registered state only. No combinational path from in_valid to full.
- out_ready has no effect when out_valid=0.
- The producer is not back-pressured: the FSM has no stall. Losses are reported only via overflow and drop_count.

Test Plan:
- Async reset: pulse reset_n low between clock edges with 2 entries held -> count=0, empty=1, out_valid=0, overflow=0 immediately, without waiting for clk.
- Push 0x03, 0x05, 0x07 on consecutive cycles, out_ready=0 -> count=3, out_data=0x03, out_seq=0.
- Continuing the previous case, then out_ready=1 for 3 cycles -> pops 0x03/0, 0x05/1, 0x07/2 in order, then empty=1.
- Push 6 words (0x10..0x15) with out_ready=0, DEPTH=4 -> full=1, count=4, overflow=1, drop_count=2.
- Continuing the previous case, pop all -> 0x10..0x13 with seq 0..3.
- At full, in_valid=1 (0xAA) with out_ready=1 for one cycle -> push accepted, count stays 4, overflow stays 0, tail seq=4.
- 256 push/pop pairs (run two FSM cycles back-to-back to generate strobes) -> out_seq runs 0..255, then the 257th entry has seq 0.
- Force 300 drops -> drop_count holds 255.
- clear asserted with in_valid=1 and a pending pop at count=3 -> next cycle count=0, empty=1, overflow=0, drop_count=0.
- Then push 0x42 -> out_seq=0, out_data=0x42.
